red_pitaya_pid_sp_ramp: RTL and testbench

//  Setpoint sequencer for the 4-block MIMO PID (blocks 11,12,21,22). Each channel slews its

---
 rtl/red_pitaya_pid_sp_ramp.sv | 177 +++++++++++++++++
 tb/tb_red_pitaya_pid_sp_ramp.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_pid_sp_ramp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : red_pitaya_pid_sp_ramp                                           |
// | Brief   : Setpoint sequencer for the 4-block MIMO PID. Each channel slews  |
// |           its setpoint toward a bus-written target in bounded steps at a   |
// |           programmable rate and drives the integrator-reset lines.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module red_pitaya_pid_sp_ramp #(
    parameter int DW   = 14,
    parameter int DIVW = 16
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [31:0]     sys_addr,
    input  logic [31:0]     sys_wdata,
    input  logic [3:0]      sys_sel,
    input  logic            sys_wen,
    input  logic            sys_ren,
    output logic [31:0]     sys_rdata,
    output logic            sys_err,
    output logic            sys_ack,
    output logic [4*DW-1:0] sp_o,
    output logic [3:0]      irst_o,
    output logic [3:0]      busy_o
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_ramp = 1'b1;

    logic [19:0]               w_addr;
    logic [DW-1:0]             w_wdata;
    logic                      w_ctrl_wr;
    logic [3:0]                w_abort;
    logic [3:0]                r_ctrl_irst;
    logic [3:0]                r_ctrl_en;
    logic [3:0]                r_irst;
    logic [3:0]                w_busy;
    logic [3:0][DW-1:0]        w_cur_all;
    logic [3:0][DW-1:0]        w_tgt_all;
    logic [3:0][DW-1:0]        w_step_all;
    logic [3:0][DIVW-1:0]      w_div_all;
    logic [31:0]               w_rdata;
    logic                      w_unused;

    assign w_addr    = sys_addr[19:0];
    assign w_wdata   = sys_wdata[DW-1:0];
    assign w_ctrl_wr = sys_wen && (w_addr == 20'h0);
    // abort bits are a one-shot qualifier of the CTRL write, never stored
    assign w_abort   = w_ctrl_wr ? sys_wdata[7:4] : 4'h0;
    assign w_unused  = &{1'b0, sys_sel, sys_ren, sys_addr[31:20], sys_wdata[31:DIVW]};

    // CTRL register: manual integrator resets and irst-during-ramp enables
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_ctrl_irst <= 4'hF;
            r_ctrl_en   <= 4'h0;
        end else if (w_ctrl_wr) begin
            r_ctrl_irst <= sys_wdata[3:0];
            r_ctrl_en   <= sys_wdata[11:8];
        end
    end

    // integrator reset output lags the channel state by one clock
    always_ff @(posedge clk_i) begin
        if (!rstn_i) r_irst <= 4'hF;
        else         r_irst <= r_ctrl_irst | (r_ctrl_en & w_busy);
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
        localparam logic [19:0] c_base = 20'(32'h10 + 32'h10 * gi);

        logic [0:0]            r_state, w_state_nxt;
        logic [DW-1:0]         r_cur, r_target, r_step;
        logic [DW-1:0]         w_cur_nxt, w_target_nxt, w_cur_step;
        logic [DIVW-1:0]       r_div, r_cnt, w_cnt_nxt;
        logic                  w_wr_tgt, w_wr_step, w_wr_div, w_upd, w_close;
        logic signed [DW:0]    w_diff;
        logic [DW:0]           w_mag;

        assign w_wr_tgt  = sys_wen && (w_addr == c_base);
        assign w_wr_step = sys_wen && (w_addr == c_base + 20'h4);
        assign w_wr_div  = sys_wen && (w_addr == c_base + 20'h8);
        assign w_upd     = (r_state == c_st_ramp) && (r_cnt == r_div);
        // signed distance is one bit wider than the setpoint so it cannot wrap
        assign w_diff    = $signed({r_target[DW-1], r_target}) - $signed({r_cur[DW-1], r_cur});
        assign w_mag     = w_diff[DW] ? DW'(0) - w_diff : w_diff;
        assign w_close   = w_mag <= {1'b0, r_step};
        // only used when the remaining distance exceeds STEP, so it never overshoots
        assign w_cur_step = w_diff[DW] ? r_cur - r_step : r_cur + r_step;

        // state register
        always_ff @(posedge clk_i) begin
            if (!rstn_i) r_state <= c_st_idle;
            else         r_state <= w_state_nxt;
        end

        // next-state: target writes, aborts and the final update end or start a ramp
        always_comb begin
            w_state_nxt = r_state;
            if (w_wr_tgt) begin
                if ((r_step == '0) || (w_wdata == r_cur)) w_state_nxt = c_st_idle;
                else                                      w_state_nxt = c_st_ramp;
            end else if (r_state == c_st_ramp) begin
                if (w_abort[gi])           w_state_nxt = c_st_idle;
                else if (w_upd && w_close) w_state_nxt = c_st_idle;
            end
        end

        // datapath next values: prescaler, setpoint step and target capture
        always_comb begin
            w_cur_nxt    = r_cur;
            w_target_nxt = r_target;
            w_cnt_nxt    = r_cnt;
            if (w_wr_tgt) begin
                w_target_nxt = w_wdata;
                w_cnt_nxt    = '0;
                if (r_step == '0) w_cur_nxt = w_wdata;
            end else if (r_state == c_st_ramp) begin
                if (w_abort[gi]) begin
                    w_target_nxt = r_cur;
                    w_cnt_nxt    = '0;
                end else if (w_upd) begin
                    w_cnt_nxt = '0;
                    w_cur_nxt = w_close ? r_target : w_cur_step;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        end

        // channel registers
        always_ff @(posedge clk_i) begin
            if (!rstn_i) begin
                r_cur    <= '0;
                r_target <= '0;
                r_cnt    <= '0;
                r_step   <= '0;
                r_div    <= '0;
            end else begin
                r_cur    <= w_cur_nxt;
                r_target <= w_target_nxt;
                r_cnt    <= w_cnt_nxt;
                if (w_wr_step) r_step <= w_wdata;
                if (w_wr_div)  r_div  <= sys_wdata[DIVW-1:0];
            end
        end

        assign w_busy[gi]     = (r_state == c_st_ramp);
        assign w_cur_all[gi]  = r_cur;
        assign w_tgt_all[gi]  = r_target;
        assign w_step_all[gi] = r_step;
        assign w_div_all[gi]  = r_div;
        assign sp_o[gi*DW +: DW] = r_cur;
    end

    // combinational read decode, zero-extended, unmapped addresses read 0
    always_comb begin
        w_rdata = '0;
        if (w_addr == 20'h0)      w_rdata = {20'h0, r_ctrl_en, 4'h0, r_ctrl_irst};
        else if (w_addr == 20'h4) w_rdata = {28'h0, w_busy};
        for (int c = 0; c < 4; c++) begin
            if (w_addr == 20'(16 * c + 16)) w_rdata = 32'(w_tgt_all[c]);
            if (w_addr == 20'(16 * c + 20)) w_rdata = 32'(w_step_all[c]);
            if (w_addr == 20'(16 * c + 24)) w_rdata = 32'(w_div_all[c]);
            if (w_addr == 20'(16 * c + 28)) w_rdata = 32'(w_cur_all[c]);
        end
    end

    assign sys_rdata = w_rdata;
    assign sys_err   = 1'b0;
    assign sys_ack   = 1'b1;
    assign irst_o    = r_irst;
    assign busy_o    = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_pid_sp_ramp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_red_pitaya_pid_sp_ramp                                        |
// | Brief   : Bench for the setpoint sequencer: directed ramps, random ramps   |
// |           with random aborts, register map and reset behaviour.           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_red_pitaya_pid_sp_ramp;

    localparam int DW   = 14;
    localparam int DIVW = 16;

    logic            clk = 1'b0;
    logic            rstn_i;
    logic [31:0]     sys_addr, sys_wdata, sys_rdata;
    logic [3:0]      sys_sel;
    logic            sys_wen, sys_ren, sys_err, sys_ack;
    logic [4*DW-1:0] sp_o;
    logic [3:0]      irst_o, busy_o;

    red_pitaya_pid_sp_ramp #(.DW(DW), .DIVW(DIVW)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .sys_addr(sys_addr), .sys_wdata(sys_wdata),
        .sys_sel(sys_sel), .sys_wen(sys_wen), .sys_ren(sys_ren), .sys_rdata(sys_rdata),
        .sys_err(sys_err), .sys_ack(sys_ack), .sp_o(sp_o), .irst_o(irst_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // reference model: setpoint/target values as plain signed integers
    int       m_cur[4], m_tgt[4], m_step[4], m_div[4];
    logic [3:0] m_irst, m_en, m_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] exp_sp();
        logic [63:0] e = '0;
        for (int c = 0; c < 4; c++) begin
            int v = m_cur[c];
            e[c*DW +: DW] = v[DW-1:0];
        end
        return e;
    endfunction

    function automatic logic [31:0] z14(input int v);
        return {18'h0, v[13:0]};
    endfunction

    // setpoint t clocks after the target-write edge, from plain slew arithmetic
    function automatic int traj(input int start, input int tgt, input int step, input int dv, input int t);
        int d   = tgt - start;
        int mag = (d < 0) ? -d : d;
        int k   = t / (dv + 1);
        if (step == 0 || k * step >= mag) return tgt;
        return (d > 0) ? start + k * step : start - k * step;
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
        @(posedge clk);
        #1 sys_wen = 1'b0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] e, input string tag);
        @(negedge clk);
        sys_addr = a; sys_ren = 1'b1;
        #1 chk(tag, 64'(sys_rdata), 64'(e));
        sys_ren = 1'b0;
    endtask

    task automatic set_ctrl(input logic [3:0] irst, input logic [3:0] en);
        wr(32'h0, {20'h0, en, 4'h0, irst});
        m_irst = irst; m_en = en;
    endtask

    task automatic set_sd(input int ch, input int step, input int dv);
        wr(32'(16 * ch + 20), z14(step));
        wr(32'(16 * ch + 24), 32'(dv));
        m_step[ch] = step & 16'h3FFF; m_div[ch] = dv;
    endtask

    // write a new target, optionally abort at clock abort_t, and check every cycle
    task automatic run_ramp(input int ch, input int tgt, input int abort_t);
        int start = m_cur[ch];
        int step  = m_step[ch];
        int dv    = m_div[ch];
        int d     = tgt - start;
        int mag   = (d < 0) ? -d : d;
        int tend;
        bit aborted = 0;
        logic [3:0] e_irst;
        if (step == 0 || mag == 0) tend = 2;
        else tend = ((mag + step - 1) / step) * (dv + 1) + 2;
        if (abort_t >= 0 && tend < abort_t + 2) tend = abort_t + 2;
        for (int t = 0; t <= tend; t++) begin
            @(negedge clk);
            if (t == 0) begin
                sys_addr = 32'(16 * ch + 16); sys_wdata = z14(tgt); sys_wen = 1'b1;
            end else if (t == abort_t) begin
                sys_addr = 32'h0; sys_wdata = {20'h0, m_en, 4'(1 << ch), m_irst}; sys_wen = 1'b1;
            end else begin
                sys_wen = 1'b0;
            end
            @(posedge clk);
            #1;
            e_irst = m_irst | (m_en & m_busy);
            if (t == 0) m_tgt[ch] = tgt;
            if (t == abort_t && m_busy[ch]) begin
                aborted   = 1;
                m_tgt[ch] = m_cur[ch];
            end
            if (!aborted) m_cur[ch] = traj(start, tgt, step, dv, t);
            m_busy[ch] = (m_cur[ch] != m_tgt[ch]);
            chk($sformatf("sp ch%0d t%0d", ch, t), 64'(sp_o), exp_sp());
            chk($sformatf("busy ch%0d t%0d", ch, t), 64'(busy_o), 64'(m_busy));
            chk($sformatf("irst ch%0d t%0d", ch, t), 64'(irst_o), 64'(e_irst));
        end
        sys_wen = 1'b0;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_cur[c] = 0; m_tgt[c] = 0; m_step[c] = 0; m_div[c] = 0;
        end
        m_irst = 4'hF; m_en = 4'h0; m_busy = 4'h0;
    endtask

    task automatic check_regs(input string tag);
        rd_chk(32'h0, {20'h0, m_en, 4'h0, m_irst}, {tag, " CTRL"});
        rd_chk(32'h4, {28'h0, m_busy}, {tag, " STAT"});
        for (int c = 0; c < 4; c++) begin
            rd_chk(32'(16 * c + 16), z14(m_tgt[c]), $sformatf("%s TARGET%0d", tag, c));
            rd_chk(32'(16 * c + 20), z14(m_step[c]), $sformatf("%s STEP%0d", tag, c));
            rd_chk(32'(16 * c + 24), 32'(m_div[c]), $sformatf("%s DIV%0d", tag, c));
            rd_chk(32'(16 * c + 28), z14(m_cur[c]), $sformatf("%s CUR%0d", tag, c));
        end
    endtask

    initial begin
        rstn_i = 1'b0; sys_addr = '0; sys_wdata = '0; sys_sel = 4'hF;
        sys_wen = 1'b0; sys_ren = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset sp", 64'(sp_o), 64'h0);
        chk("reset busy", 64'(busy_o), 64'h0);
        chk("reset irst", 64'(irst_o), 64'hF);
        chk("ack", 64'(sys_ack), 64'h1);
        chk("err", 64'(sys_err), 64'h0);
        @(negedge clk) rstn_i = 1'b1;
        check_regs("rst");
        rd_chk(32'h8, 32'h0, "unmapped 0x08");
        rd_chk(32'h50, 32'h0, "unmapped 0x50");
        wr(32'h8, 32'hFFFF_FFFF);
        wr(32'h1C, 32'd123);
        rd_chk(32'h8, 32'h0, "unmapped write");
        rd_chk(32'h1C, 32'h0, "CUR read-only");

        // ch11: +100 every 10 clocks to 1000, irst follows busy
        set_ctrl(4'h0, 4'h1);
        @(posedge clk); #1;
        chk("irst cleared", 64'(irst_o), 64'h0);
        set_sd(0, 100, 9);
        run_ramp(0, 1000, -1);
        // ch12: 300,600,900,1000 on consecutive clocks
        set_sd(1, 300, 0);
        run_ramp(1, 1000, -1);
        // ch21: jump to 0x1FFF, then full-scale step to 0x2000 without wrapping
        set_sd(2, 0, 0);
        run_ramp(2, 16'h1FFF, -1);
        set_sd(2, 16'h3FFF, 0);
        run_ramp(2, -8192, -1);
        // ch22: ramp to 500, abort once CUR is 200
        set_sd(3, 10, 3);
        run_ramp(3, 500, 81);
        chk("abort frozen", 64'(m_cur[3]), 64'd200);
        check_regs("directed");

        // random ramps with random controls and occasional aborts
        for (int i = 0; i < 10; i++) begin
            int ch   = $urandom_range(0, 3);
            int step = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(300, 16383);
            int dv   = $urandom_range(0, 4);
            int tgt  = $urandom_range(0, 16383) - 8192;
            int ab   = -1;
            set_ctrl(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            set_sd(ch, step, dv);
            if (step != 0 && $urandom_range(0, 1) == 1) ab = $urandom_range(1, 60);
            run_ramp(ch, tgt, ab);
            rd_chk(32'(16 * ch + 16), z14(m_tgt[ch]), $sformatf("rnd%0d TARGET", i));
            rd_chk(32'(16 * ch + 28), z14(m_cur[ch]), $sformatf("rnd%0d CUR", i));
            rd_chk(32'h0, {20'h0, m_en, 4'h0, m_irst}, $sformatf("rnd%0d CTRL", i));
        end

        // reset in the middle of a ramp
        set_ctrl(4'h0, 4'hF);
        set_sd(0, 50, 0);
        wr(32'h10, 32'd3000);
        repeat (3) @(posedge clk);
        @(negedge clk) rstn_i = 1'b0;
        @(posedge clk); #1;
        model_reset();
        chk("midreset sp", 64'(sp_o), 64'h0);
        chk("midreset busy", 64'(busy_o), 64'h0);
        chk("midreset irst", 64'(irst_o), 64'hF);
        @(negedge clk) rstn_i = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("postreset sp", 64'(sp_o), 64'h0);
        check_regs("midreset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
